// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- serialises words pulled from an upstream FIFO onto a UART line.
//
// Each frame is: start bit (0), DATA_WIDTH payload bits LSB first, an optional
// even-parity bit, and one stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert the even-parity bit
// (XOR of all payload bits) between the last data bit and the stop bit.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   tx_enable   permits starting new frames (never aborts a frame in flight)
//   fifo_empty  upstream FIFO empty flag, only looked at in IDLE
//   fifo_rd_en  registered one-cycle read strobe to the upstream FIFO
//   fifo_data   upstream registered read data, valid the cycle after fifo_rd_en
//   tx          registered serial output, idle high
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse on the last cycle of the stop bit
//   state_dbg   current FSM state encoding, for observation only
//
// FIFO read handshake: in IDLE, when tx_enable=1 and fifo_empty=0, the FSM moves
// to FETCH and fifo_rd_en is high for exactly that FETCH cycle; the FIFO presents
// the word during the following LOAD cycle, where it is captured. One read per
// frame, never issued while fifo_empty=1.

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            state_dbg
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d, baud_inc;
    logic [IW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);
    assign baud_inc  = baud_last ? '0 : baud_q + 1'b1;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        rd_en_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_enable && !fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                sreg_d  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
                state_d = S_START;
            end
            S_START: begin
                baud_d = baud_inc;
                if (baud_last) state_d = S_DATA;
            end
            S_DATA: begin
                baud_d = baud_inc;
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sreg_d = sreg_q >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = baud_inc;
                if (baud_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                baud_d = baud_inc;
                if (baud_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is registered from the next state so the line lines up with the state
    // register: the first START cycle already shows 0, each DATA bit shows the
    // post-shift LSB.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && baud_last;
    assign state_dbg  = state_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame; SHALL be 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; SHALL be >= 2.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 tx_enable  input  1  permits starting new frames.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_rd_en  output  1  read strobe to upstream FIFO, registered.
REQ-008 fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid the cycle after fifo_rd_en.
REQ-009 tx  output  1  serial line, idle high, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, (PARITY), STOP.
- IDLE: if tx_enable=1 and fifo_empty=0, assert fifo_rd_en for exactly one cycle -> FETCH.
- FETCH: wait one cycle for FIFO read latency -> LOAD.
- LOAD: capture fifo_data into shift register -> START.
REQ-013 START SHALL drive tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-014 DATA SHALL shift out DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles; then -> PARITY if compiled in, else STOP.
REQ-015 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, pulse frame_done on its last cycle, then -> IDLE.
REQ-016 Baud counter width SHALL be $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary; bit index SHALL count 0..DATA_WIDTH-1.
REQ-017 fifo_rd_en SHALL never assert when fifo_empty=1, and never more than once per frame.
REQ-018 Back-to-back: with data available, the next frame's start bit SHALL begin exactly 3 cycles after the STOP state exits (IDLE, FETCH, LOAD), tx held 1 meanwhile.
REQ-019 tx_enable deasserted mid-frame SHALL NOT abort the frame; it only blocks the next fetch in IDLE.
REQ-020 fifo_empty changes outside IDLE SHALL be ignored.
REQ-021 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.

Reset
REQ-022 While rst_n=0 at a clock edge: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, counters and shift register cleared.
REQ-023 Reset mid-frame SHALL abandon the frame; tx SHALL be 1 the cycle after the reset edge; the byte already read is lost.

Configuration
REQ-024 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = XOR of all payload bits (even parity) for CLKS_PER_BIT cycles.
REQ-025 Macro undefined: no PARITY state, no parity logic; DATA proceeds directly to STOP.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-026 Reset then idle: fifo_empty=1, tx_enable=1 for 50 cycles -> tx=1, busy=0, fifo_rd_en never asserted.
REQ-027 Single byte 0xA5, no parity: tx = 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4; frame_done one pulse; total 40 cycles from START entry.
REQ-028 With FIFO_UART_TX_PARITY_EN, byte 0xA5: parity bit 0 inserted before stop, 44 cycles; byte 0x07: parity bit 1.
REQ-029 Three bytes 0x01,0x80,0xFF queued: exactly 3 fifo_rd_en pulses, 3-cycle idle gap between frames, bytes serialized in order.
REQ-030 tx_enable dropped during bit 3 of byte 0x3C: frame completes intact, no further fifo_rd_en while fifo_empty=0 until tx_enable=1.
REQ-031 rst_n=0 during DATA bit 5: tx=1 next cycle, busy=0, frame_done never pulses; after release, next queued byte sent from a fresh start bit.
